// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between an instruction-fetch requester and
// a data (load/store) requester. Data requests normally win a collision, but
// after STARVE_LIMIT consecutive data grants with a fetch waiting, the fetch
// is granted. Each access keeps the port busy for LATENCY cycles, followed
// by one DONE cycle that carries the ready pulse.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   if_req, if_addr             fetch request and address
//   if_rdata, if_ready          fetched word, one-cycle completion pulse
//   dm_req, dm_we, dm_addr,     data request: 1 = store / 0 = load, address,
//   dm_wdata                    store data
//   dm_rdata, dm_ready          load result, one-cycle completion pulse
//   mem_en, mem_we, mem_addr,   shared memory port (registered)
//   mem_wdata, mem_rdata        mem_rdata is valid in the last busy cycle
//   stall_if, stall_pipe        requester stalls (req held, no ready yet)
module mem_port_arbiter #(
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_pipe
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] BUSY_LOAD  = 4'(LATENCY - 1);
  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

  state_t      state_r;
  state_t      state_next_s;
  logic        grant_if_s;
  logic        grant_dm_s;
  logic        busy_last_s;
  logic [3:0]  busy_cnt_r;
  logic [3:0]  streak_r;
  logic        mem_en_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic [31:0] if_rdata_r;
  logic [31:0] dm_rdata_r;
  logic        if_ready_r;
  logic        dm_ready_r;

  // Next-state and grant decode.
  always_comb begin
    state_next_s = state_r;
    grant_if_s   = 1'b0;
    grant_dm_s   = 1'b0;
    busy_last_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (if_req && dm_req) begin
          // Data wins collisions until the fetch has been passed over
          // STARVE_LIMIT times in a row.
          if (streak_r == STREAK_MAX) begin
            grant_if_s = 1'b1;
          end else begin
            grant_dm_s = 1'b1;
          end
        end else if (if_req) begin
          grant_if_s = 1'b1;
        end else if (dm_req) begin
          grant_dm_s = 1'b1;
        end else begin
          grant_if_s = 1'b0;
        end
        if (grant_if_s) begin
          state_next_s = BUSY_IF;
        end else if (grant_dm_s) begin
          state_next_s = BUSY_DM;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (busy_cnt_r == 4'd0) begin
          busy_last_s  = 1'b1;
          state_next_s = DONE;
        end else begin
          state_next_s = state_r;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Memory port, busy counter, read-data capture and ready pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      busy_cnt_r  <= 4'd0;
      if_rdata_r  <= 32'h0000_0000;
      dm_rdata_r  <= 32'h0000_0000;
      if_ready_r  <= 1'b0;
      dm_ready_r  <= 1'b0;
    end else begin
      if_ready_r <= busy_last_s && (state_r == BUSY_IF);
      dm_ready_r <= busy_last_s && (state_r == BUSY_DM);
      if (grant_if_s) begin
        mem_en_r    <= 1'b1;
        mem_we_r    <= 1'b0;
        mem_addr_r  <= if_addr;
        mem_wdata_r <= 32'h0000_0000;
        busy_cnt_r  <= BUSY_LOAD;
      end else if (grant_dm_s) begin
        mem_en_r    <= 1'b1;
        mem_we_r    <= dm_we;
        mem_addr_r  <= dm_addr;
        mem_wdata_r <= dm_wdata;
        busy_cnt_r  <= BUSY_LOAD;
      end else if (busy_last_s) begin
        mem_en_r <= 1'b0;
        mem_we_r <= 1'b0;
        if (state_r == BUSY_IF) begin
          if_rdata_r <= mem_rdata;
        end else if (!mem_we_r) begin
          dm_rdata_r <= mem_rdata;
        end
      end else if (mem_en_r) begin
        busy_cnt_r <= busy_cnt_r - 4'd1;
      end
    end
  end

  // Count data grants that bypassed a waiting fetch; saturates at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_r <= 4'd0;
    end else if (grant_if_s) begin
      streak_r <= 4'd0;
    end else if (grant_dm_s) begin
      if (!if_req) begin
        streak_r <= 4'd0;
      end else if (streak_r < STREAK_MAX) begin
        streak_r <= streak_r + 4'd1;
      end
    end
  end

  assign mem_en     = mem_en_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign if_rdata   = if_rdata_r;
  assign dm_rdata   = dm_rdata_r;
  assign if_ready   = if_ready_r;
  assign dm_ready   = dm_ready_r;
  assign stall_if   = if_req & ~if_ready_r;
  assign stall_pipe = dm_req & ~dm_ready_r;

endmodule
